// File: rtl/harmonic_mix_player_if.sv
// Port bundle for harmonic_mix_player: note control, weight programming, codec request/response
// and the shared sine-ROM port. The slave modport is the player's view, master the driver's view.
interface harmonic_mix_player_if #(
    parameter int NUM_HARMONICS = 7,
    parameter int STEP_WIDTH    = 20,
    parameter int ADDR_WIDTH    = 10,
    parameter int SAMPLE_WIDTH  = 16,
    parameter int DUR_WIDTH     = 6
);
    localparam int IDX_W = (NUM_HARMONICS > 1) ? $clog2(NUM_HARMONICS) : 1;

    logic                    play_enable;
    logic                    load_new_note;
    logic [STEP_WIDTH-1:0]   step_in;
    logic [DUR_WIDTH-1:0]    duration_to_load;
    logic                    beat;
    logic                    done_with_note;
    logic                    wgt_we;
    logic [IDX_W-1:0]        wgt_idx;
    logic [3:0]              wgt_shift;
    logic                    generate_next_sample;
    logic [ADDR_WIDTH-1:0]   sine_addr;
    logic [SAMPLE_WIDTH-1:0] sine_data;
    logic [SAMPLE_WIDTH-1:0] sample_out;
    logic                    new_sample_ready;
    logic [2:0]              dbg_state;

    modport slave (
        input  play_enable, load_new_note, step_in, duration_to_load, beat,
        input  wgt_we, wgt_idx, wgt_shift, generate_next_sample, sine_data,
        output done_with_note, sine_addr, sample_out, new_sample_ready, dbg_state
    );

    modport master (
        output play_enable, load_new_note, step_in, duration_to_load, beat,
        output wgt_we, wgt_idx, wgt_shift, generate_next_sample, sine_data,
        input  done_with_note, sine_addr, sample_out, new_sample_ready, dbg_state
    );
endinterface

// File: rtl/harmonic_mix_player.sv
// Harmonic-mix note player: NUM_HARMONICS phase accumulators share one sine-ROM port, mixed with
// programmable shift weights. Define HARMONIC_MIX_ENVELOPE_EN for the beat-driven gain envelope.
module harmonic_mix_player #(
    parameter int NUM_HARMONICS = 7,
    parameter int STEP_WIDTH    = 20,
    parameter int ADDR_WIDTH    = 10,
    parameter int SAMPLE_WIDTH  = 16,
    parameter int DUR_WIDTH     = 6
) (
    input logic clk,
    input logic reset,
    harmonic_mix_player_if.slave bus
);
    localparam int IDX_W = (NUM_HARMONICS > 1) ? $clog2(NUM_HARMONICS) : 1;
    localparam int ACC_W = SAMPLE_WIDTH + $clog2(NUM_HARMONICS) + 1;
    localparam int WIDE  = ACC_W + 6;
    localparam logic [IDX_W-1:0] LAST_H = IDX_W'(NUM_HARMONICS - 1);
    localparam logic [IDX_W:0]   N_EXT  = (IDX_W + 1)'(NUM_HARMONICS);
    localparam logic signed [WIDE-1:0] SAT_MAX = WIDE'(2 ** (SAMPLE_WIDTH - 1) - 1);
    localparam logic signed [WIDE-1:0] SAT_MIN = ~SAT_MAX;

    // Handshake: generate_next_sample is sampled only in IDLE (a one-cycle accept); the mixed
    // result appears on sample_out together with a one-cycle new_sample_ready pulse in OUT.
    typedef enum logic [2:0] {IDLE, RUN, DRAIN, SCALE, OUT} state_t;
    state_t state, state_nx;

    logic [STEP_WIDTH-1:0]   step_q, mult_q;
    logic [STEP_WIDTH-1:0]   phase_q  [NUM_HARMONICS];
    logic [3:0]              wgt_q    [NUM_HARMONICS];
    logic [3:0]              wgt_snap [NUM_HARMONICS];
    logic [DUR_WIDTH-1:0]    countdown;
    logic                    done_q;
    logic [IDX_W-1:0]        h_q, h_nx, dat_h;
    logic                    dat_vld;
    logic signed [SAMPLE_WIDTH-1:0] data_s, sample_q;
    logic signed [ACC_W-1:0] acc_q, term, acc_sum, data_ext;
    logic signed [WIDE-1:0]  acc_wide;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    sounding;

    function automatic logic signed [SAMPLE_WIDTH-1:0] sat(input logic signed [WIDE-1:0] v);
        if (v > SAT_MAX)      sat = SAT_MAX[SAMPLE_WIDTH-1:0];
        else if (v < SAT_MIN) sat = SAT_MIN[SAMPLE_WIDTH-1:0];
        else                  sat = v[SAMPLE_WIDTH-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            countdown <= '0;
            done_q    <= 1'b1;
            step_q    <= '0;
        end else if (bus.load_new_note) begin
            step_q    <= bus.step_in;
            countdown <= bus.duration_to_load;
            done_q    <= (bus.duration_to_load == '0);
        end else if (bus.beat && bus.play_enable && countdown != '0) begin
            countdown <= countdown - 1'b1;
            done_q    <= (countdown == DUR_WIDTH'(1));
        end
    end

    // Reset instrument: h0 holds shift value 1, every other harmonic muted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int h = 0; h < NUM_HARMONICS; h++) wgt_q[h] <= (h == 0) ? 4'd1 : 4'hF;
        end else if (bus.wgt_we && ({1'b0, bus.wgt_idx} < N_EXT)) begin
            wgt_q[bus.wgt_idx] <= bus.wgt_shift;
        end
    end

`ifdef HARMONIC_MIX_ENVELOPE_EN
    logic [4:0]             gain;
    logic signed [ACC_W-1:0] mix_q;
    logic signed [WIDE-1:0] mix_wide, gain_wide, scaled;

    always_ff @(posedge clk) begin
        if (!reset) begin
            gain <= '0;
        end else if (bus.load_new_note) begin
            gain <= '0;
        end else if (bus.beat && bus.play_enable) begin
            if (!done_q) begin
                if (gain < 5'd16) gain <= gain + 1'b1;
            end else if (gain != '0) begin
                gain <= gain - 1'b1;
            end
        end
    end

    assign sounding = (!done_q || gain != '0) && bus.play_enable;

    always_comb begin
        mix_wide  = mix_q;
        gain_wide = {{(WIDE - 5){1'b0}}, gain};
        scaled    = (mix_wide * gain_wide) >>> 4;
    end
`else
    assign sounding = !done_q && bus.play_enable;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (bus.generate_next_sample) state_nx = RUN;
            RUN:   if (h_q == LAST_H) state_nx = DRAIN;
`ifdef HARMONIC_MIX_ENVELOPE_EN
            DRAIN: state_nx = SCALE;
`else
            DRAIN: state_nx = OUT;
`endif
            SCALE: state_nx = OUT;
            OUT:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ROM data arriving this cycle belongs to the harmonic addressed one cycle earlier (dat_h).
    always_comb begin
        h_nx     = h_q + 1'b1;
        data_s   = bus.sine_data;
        data_ext = data_s;
        term     = '0;
        if (dat_vld && wgt_snap[dat_h] != 4'hF) term = data_ext >>> wgt_snap[dat_h];
        acc_sum  = acc_q + term;
        acc_wide = acc_sum;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            h_q      <= '0;
            dat_h    <= '0;
            dat_vld  <= 1'b0;
            acc_q    <= '0;
            addr_q   <= '0;
            mult_q   <= '0;
            sample_q <= '0;
            for (int h = 0; h < NUM_HARMONICS; h++) begin
                phase_q[h]  <= '0;
                wgt_snap[h] <= 4'hF;
            end
`ifdef HARMONIC_MIX_ENVELOPE_EN
            mix_q    <= '0;
`endif
        end else begin
            state   <= state_nx;
            dat_vld <= (state == RUN);
            dat_h   <= h_q;
            case (state)
                IDLE: if (bus.generate_next_sample) begin
                    acc_q    <= '0;
                    h_q      <= '0;
                    mult_q   <= step_q;
                    addr_q   <= phase_q[0][STEP_WIDTH-1 -: ADDR_WIDTH];
                    wgt_snap <= wgt_q;
                end
                RUN: begin
                    acc_q  <= acc_sum;
                    mult_q <= mult_q + step_q;
                    if (h_q != LAST_H) begin
                        h_q    <= h_nx;
                        addr_q <= phase_q[h_nx][STEP_WIDTH-1 -: ADDR_WIDTH];
                    end
                    // mult_q holds (h+1)*step for the harmonic whose address is already out.
                    if (sounding) phase_q[h_q] <= phase_q[h_q] + mult_q;
                end
                DRAIN: begin
                    acc_q <= acc_sum;
`ifdef HARMONIC_MIX_ENVELOPE_EN
                    mix_q <= sounding ? acc_sum : '0;
`else
                    sample_q <= sounding ? sat(acc_wide) : '0;
`endif
                end
`ifdef HARMONIC_MIX_ENVELOPE_EN
                SCALE: sample_q <= sat(scaled);
`endif
                default: ;
            endcase
            if (bus.load_new_note) begin
                for (int h = 0; h < NUM_HARMONICS; h++) phase_q[h] <= '0;
            end
        end
    end

    assign bus.done_with_note   = done_q;
    assign bus.sine_addr        = addr_q;
    assign bus.sample_out       = sample_q;
    assign bus.new_sample_ready = (state == OUT);
    assign bus.dbg_state        = state;
endmodule

// File: tb/tb_harmonic_mix_player.sv
// Directed bench for harmonic_mix_player (default build): reset, phase addressing, mixing and
// saturation, note countdown, request filtering and weight snapshot timing.
module tb_harmonic_mix_player;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    harmonic_mix_player_if bus ();
    harmonic_mix_player dut (.clk(clk), .reset(reset), .bus(bus));

    // Synchronous ROM model: constant word, one cycle after the address.
    logic [15:0] rom_val = 16'h4000;
    always @(posedge clk) bus.sine_data <= rom_val;

    int tests = 0;
    int fails = 0;
    logic [15:0] exp_q[$];
    logic [9:0]  a0, a1;
    int          pulses, lat;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_note(input logic [19:0] step, input logic [5:0] dur, input logic with_beat);
        bus.load_new_note    = 1'b1;
        bus.step_in          = step;
        bus.duration_to_load = dur;
        bus.beat             = with_beat;
        tick();
        bus.load_new_note = 1'b0;
        bus.beat          = 1'b0;
    endtask

    task automatic do_beat(input logic pe);
        bus.play_enable = pe;
        bus.beat        = 1'b1;
        tick();
        bus.beat        = 1'b0;
        bus.play_enable = 1'b1;
    endtask

    task automatic set_wgt(input logic [2:0] idx, input logic [3:0] shift);
        bus.wgt_we    = 1'b1;
        bus.wgt_idx   = idx;
        bus.wgt_shift = shift;
        tick();
        bus.wgt_we = 1'b0;
    endtask

    task automatic set_all_wgt(input logic [3:0] shift);
        for (int i = 0; i < 7; i++) set_wgt(3'(i), shift);
    endtask

    task automatic gen_sample(input string tag, input logic [15:0] exp,
                              output logic [9:0] addr0, output logic [9:0] addr1);
        int l;
        exp_q.push_back(exp);
        bus.generate_next_sample = 1'b1;
        tick();
        bus.generate_next_sample = 1'b0;
        l = 1;
        addr0 = bus.sine_addr;
        tick();
        l = 2;
        addr1 = bus.sine_addr;
        while (bus.new_sample_ready !== 1'b1 && l < 30) begin
            tick();
            l++;
        end
        check({tag, " latency"}, l, 9);
        check(tag, bus.sample_out, exp_q.pop_front());
        tick();
        check({tag, " pulse width"}, bus.new_sample_ready, 1'b0);
    endtask

    initial begin
        bus.play_enable = 1'b1;
        bus.load_new_note = 1'b0;
        bus.step_in = '0;
        bus.duration_to_load = '0;
        bus.beat = 1'b0;
        bus.wgt_we = 1'b0;
        bus.wgt_idx = '0;
        bus.wgt_shift = '0;
        bus.generate_next_sample = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("reset sample_out", bus.sample_out, 16'h0);
        check("reset ready", bus.new_sample_ready, 1'b0);
        check("reset done", bus.done_with_note, 1'b1);
        check("reset sine_addr", bus.sine_addr, 10'h0);
        check("reset state", bus.dbg_state, 3'd0);

        // Default weights: only h0 at shift 1.
        load_note(20'h01000, 6'd40, 1'b0);
        check("done after load", bus.done_with_note, 1'b0);
        gen_sample("default weights", 16'h2000, a0, a1);
        check("seq1 h0 addr", a0, 10'd0);
        check("seq1 h1 addr", a1, 10'd0);
        gen_sample("seq2", 16'h2000, a0, a1);
        check("seq2 h0 addr", a0, 10'd4);
        check("seq2 h1 addr", a1, 10'd8);
        gen_sample("seq3", 16'h2000, a0, a1);
        check("seq3 h0 addr", a0, 10'd8);
        check("seq3 h1 addr", a1, 10'd16);
        load_note(20'h01000, 6'd40, 1'b0);
        gen_sample("reload", 16'h2000, a0, a1);
        check("reload clears phase", a0, 10'd0);

        // Mid-sequence reset aborts without a pulse and restores weights.
        set_wgt(3'd0, 4'd0);
        gen_sample("h0 unity", 16'h4000, a0, a1);
        bus.generate_next_sample = 1'b1;
        tick();
        bus.generate_next_sample = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        pulses = 0;
        repeat (3) begin tick(); if (bus.new_sample_ready) pulses++; end
        reset = 1'b1;
        repeat (12) begin tick(); if (bus.new_sample_ready) pulses++; end
        check("abort pulses", pulses, 0);
        check("abort sample_out", bus.sample_out, 16'h0);
        check("abort done", bus.done_with_note, 1'b1);
        check("abort state", bus.dbg_state, 3'd0);
        load_note(20'h01000, 6'd40, 1'b0);
        gen_sample("weights restored", 16'h2000, a0, a1);

        // Saturation and arithmetic shift.
        set_all_wgt(4'd0);
        gen_sample("sat positive", 16'h7FFF, a0, a1);
        rom_val = 16'hC000;
        gen_sample("sat negative", 16'h8000, a0, a1);
        rom_val = 16'hF000;
        set_wgt(3'd6, 4'd3);
        gen_sample("negative shift", 16'h9E00, a0, a1);
        set_wgt(3'd7, 4'd0);
        gen_sample("idx 7 ignored", 16'h9E00, a0, a1);

        // Request during RUN ignored; mid-sequence weight write deferred.
        rom_val = 16'h1000;
        set_wgt(3'd6, 4'd0);
        bus.generate_next_sample = 1'b1;
        tick();
        bus.generate_next_sample = 1'b0;
        lat = 1;
        tick(); tick();
        lat = 3;
        bus.generate_next_sample = 1'b1;
        bus.wgt_we = 1'b1;
        bus.wgt_idx = 3'd2;
        bus.wgt_shift = 4'hF;
        tick();
        lat = 4;
        bus.generate_next_sample = 1'b0;
        bus.wgt_we = 1'b0;
        while (bus.new_sample_ready !== 1'b1 && lat < 30) begin tick(); lat++; end
        check("busy latency", lat, 9);
        check("write mid-seq current", bus.sample_out, 16'h7000);
        pulses = 0;
        repeat (15) begin tick(); if (bus.new_sample_ready) pulses++; end
        check("busy request pulses", pulses, 0);
        gen_sample("write mid-seq next", 16'h6000, a0, a1);

        // A write in the accept cycle is not seen by that sequence.
        bus.wgt_we = 1'b1;
        bus.wgt_idx = 3'd2;
        bus.wgt_shift = 4'd0;
        gen_sample("accept-cycle write", 16'h6000, a0, a1);
        bus.wgt_we = 1'b0;
        gen_sample("accept-cycle write later", 16'h7000, a0, a1);

        bus.play_enable = 1'b0;
        gen_sample("paused output", 16'h0000, a0, a1);
        bus.play_enable = 1'b1;

        // Countdown, pause and load priority.
        load_note(20'h00800, 6'd3, 1'b0);
        check("dur3 done", bus.done_with_note, 1'b0);
        do_beat(1'b1);
        check("beat1 done", bus.done_with_note, 1'b0);
        do_beat(1'b0);
        do_beat(1'b1);
        check("paused beat ignored", bus.done_with_note, 1'b0);
        do_beat(1'b1);
        check("beat3 done", bus.done_with_note, 1'b1);
        gen_sample("done output", 16'h0000, a0, a1);
        load_note(20'h00800, 6'd3, 1'b1);
        do_beat(1'b1);
        do_beat(1'b1);
        check("load beats beat", bus.done_with_note, 1'b0);
        do_beat(1'b1);
        check("load+beat countdown", bus.done_with_note, 1'b1);
        load_note(20'h00800, 6'd3, 1'b0);
        do_beat(1'b1);
        do_beat(1'b1);
        load_note(20'h00800, 6'd2, 1'b0);
        do_beat(1'b1);
        check("restart keeps sounding", bus.done_with_note, 1'b0);
        do_beat(1'b1);
        check("restart done", bus.done_with_note, 1'b1);
        load_note(20'h00800, 6'd0, 1'b0);
        check("dur0 done", bus.done_with_note, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
